// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state, parity encodings and prescale floor for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge counter and sample point; UART_RX_MAJORITY_EN selects 2-of-3 voting
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_s,
  input  logic                  i_start,
  input  logic                  i_run,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_bit_done,
  output logic                  o_bit
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] mid, dec_pt;

  assign mid = i_prescale >> 1;

  // The start-edge cycle is position 0 of the start bit, so the counter resumes at 1.
  always_comb begin
    edge_cnt_d = '0;
    if (i_start) begin
      edge_cnt_d = PRESCALE_W'(1);
    end else if (i_run && (edge_cnt_q != i_prescale - 1'b1)) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic early_q, early_d;
  logic centre_q, centre_d;

  always_comb begin
    early_d  = early_q;
    centre_d = centre_q;
    if (i_run && (edge_cnt_q == mid - 1'b1)) early_d = i_rx_s;
    if (i_run && (edge_cnt_q == mid)) centre_d = i_rx_s;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      early_q  <= 1'b1;
      centre_q <= 1'b1;
    end else begin
      early_q  <= early_d;
      centre_q <= centre_d;
    end
  end

  assign dec_pt = mid + 1'b1;
  assign o_bit  = (early_q & centre_q) | (early_q & i_rx_s) | (centre_q & i_rx_s);
`else
  assign dec_pt = mid;
  assign o_bit  = i_rx_s;
`endif

  assign o_bit_done = i_run && (edge_cnt_q == dec_pt);

endmodule

// File: rtl/uart_rx_ext.sv
// rtl/uart_rx_ext.sv - UART receiver with parity/stop checking; UART_RX_MAJORITY_EN enables majority sampling
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic                  i_en_par,
  input  logic                  i_par_type,
  input  logic                  i_stop2,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_data_valid,
  output logic                  o_par_err,
  output logic                  o_stop_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sync1_q, rx_s_q, rx_prev_q;
  logic fall, bit_done, bit_val, stop_bad;

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  par_acc_q, par_acc_d;
  logic                  par_flag_q, par_flag_d;
  logic                  stop_flag_q, stop_flag_d;
  logic                  en_par_q, en_par_d;
  logic                  par_type_q, par_type_d;
  logic                  stop2_q, stop2_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;

  assign fall = rx_prev_q & ~rx_s_q;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_s     (rx_s_q),
    .i_start    ((state_q == ST_IDLE) && fall),
    .i_run      (state_q != ST_IDLE),
    .i_prescale (prescale_q),
    .o_bit_done (bit_done),
    .o_bit      (bit_val)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    par_acc_d   = par_acc_q;
    par_flag_d  = par_flag_q;
    stop_flag_d = stop_flag_q;
    en_par_d    = en_par_q;
    par_type_d  = par_type_q;
    stop2_d     = stop2_q;
    prescale_d  = prescale_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    par_err_d   = 1'b0;
    stop_err_d  = 1'b0;
    stop_bad    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d     = ST_START;
          en_par_d    = i_en_par;
          par_type_d  = i_par_type;
          stop2_d     = i_stop2;
          prescale_d  = (i_prescale < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE) : i_prescale;
          bit_cnt_d   = '0;
          stop_cnt_d  = 1'b0;
          par_acc_d   = 1'b0;
          par_flag_d  = 1'b0;
          stop_flag_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) state_d = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d   = {bit_val, shift_q[DATA_W-1:1]};
          par_acc_d = par_acc_q ^ bit_val;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = en_par_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          if ((par_acc_q ^ bit_val) != (par_type_q == PAR_ODD)) par_flag_d = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving mid stop bit lets the next start edge arrive with no idle gap.
        if (bit_done) begin
          stop_bad    = stop_flag_q | ~bit_val;
          stop_flag_d = stop_bad;
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            valid_d    = ~par_flag_q & ~stop_bad;
            par_err_d  = par_flag_q;
            stop_err_d = stop_bad;
            if (valid_d) data_d = shift_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      par_flag_q  <= 1'b0;
      stop_flag_q <= 1'b0;
      en_par_q    <= 1'b0;
      par_type_q  <= PAR_EVEN;
      stop2_q     <= 1'b0;
      prescale_q  <= PRESCALE_W'(MIN_PRESCALE);
      data_q      <= '0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      stop_err_q  <= 1'b0;
    end else begin
      sync1_q     <= i_rx;
      rx_s_q      <= sync1_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      par_acc_q   <= par_acc_d;
      par_flag_q  <= par_flag_d;
      stop_flag_q <= stop_flag_d;
      en_par_q    <= en_par_d;
      par_type_q  <= par_type_d;
      stop2_q     <= stop2_d;
      prescale_q  <= prescale_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      par_err_q   <= par_err_d;
      stop_err_q  <= stop_err_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_par_err    = par_err_q;
  assign o_stop_err   = stop_err_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb/tb_uart_rx_ext.sv - scoreboard bench for uart_rx_ext at DATA_W 8 and 9; honours UART_RX_MAJORITY_EN
module tb_uart_rx_ext;
  import uart_pkg::*;

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  typedef struct {
    logic [2:0] flags;
    logic [8:0] data;
    longint     cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx8, en_par8, par_type8, stop2_8;
  logic       rx9, en_par9, par_type9, stop2_9;
  logic [5:0] pre8, pre9;
  logic [7:0] data8;
  logic [8:0] data9;
  logic       v8, p8, s8, v9, p9, s9;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  exp_t   q8[$], q9[$];
  exp_t   e8, e9;
  logic [8:0] last8 = '0, last9 = '0;

  uart_rx_ext #(.DATA_W(8), .PRESCALE_W(6)) dut8 (
    .i_clk(clk), .i_rst(rst_n), .i_rx(rx8), .i_en_par(en_par8), .i_par_type(par_type8),
    .i_stop2(stop2_8), .i_prescale(pre8), .o_data(data8), .o_data_valid(v8),
    .o_par_err(p8), .o_stop_err(s8)
  );

  uart_rx_ext #(.DATA_W(9), .PRESCALE_W(6)) dut9 (
    .i_clk(clk), .i_rst(rst_n), .i_rx(rx9), .i_en_par(en_par9), .i_par_type(par_type9),
    .i_stop2(stop2_9), .i_prescale(pre9), .o_data(data9), .o_data_valid(v9),
    .o_par_err(p9), .o_stop_err(s9)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (v8 || p8 || s8)) begin
      check("pulse8_expected", 64'(q8.size() != 0), 64'd1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        check("flags8", {v8, p8, s8}, e8.flags);
        check("data8", data8, e8.data);
        check("time8", cyc, e8.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (v9 || p9 || s9)) begin
      check("pulse9_expected", 64'(q9.size() != 0), 64'd1);
      if (q9.size() != 0) begin
        e9 = q9.pop_front();
        check("flags9", {v9, p9, s9}, e9.flags);
        check("data9", data9, e9.data);
        check("time9", cyc, e9.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int sel, input int n);
    if (sel == 8) rx8 = 1'b1; else rx9 = 1'b1;
    tick(n);
  endtask

  // glitch: frame position (0 = start bit) that gets one inverted cycle at its centre
  task automatic send(input int sel, input logic [8:0] word, input int p, input bit en_par,
                      input bit ptype, input bit pbad, input bit stop2, input bit s1,
                      input bit s2, input int glitch);
    int         nb = (sel == 8) ? 8 : 9;
    int         n = 0;
    logic [15:0] fr = '0;
    logic [8:0] sent, rdata;
    logic       par_bit, v;
    bit         par_ok, stop_ok;
    exp_t       e;
    sent  = (nb == 8) ? {1'b0, word[7:0]} : word;
    rdata = sent;
    if (MAJ == 0 && glitch >= 1 && glitch <= nb) rdata[glitch-1] = ~rdata[glitch-1];
    par_bit = (^sent) ^ ptype ^ pbad;
    par_ok  = !en_par || (((^rdata) ^ par_bit) == ptype);
    stop_ok = s1 && (!stop2 || s2);
    fr[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin fr[n] = sent[i]; n++; end
    if (en_par) begin fr[n] = par_bit; n++; end
    fr[n] = s1; n++;
    if (stop2) begin fr[n] = s2; n++; end
    if (sel == 8) begin
      en_par8 = en_par; par_type8 = ptype; stop2_8 = stop2; pre8 = 6'(p);
    end else begin
      en_par9 = en_par; par_type9 = ptype; stop2_9 = stop2; pre9 = 6'(p);
    end
    e.cyc = cyc + 2 + longint'((1 + nb + int'(en_par)) * p + p / 2 + 1 + (stop2 ? p : 0) + MAJ);
    if (par_ok && stop_ok) begin
      e.flags = 3'b100;
      e.data  = rdata;
    end else begin
      e.flags = {1'b0, !par_ok, !stop_ok};
      e.data  = (sel == 8) ? last8 : last9;
    end
    if (sel == 8) begin
      if (par_ok && stop_ok) last8 = rdata;
      q8.push_back(e);
    end else begin
      if (par_ok && stop_ok) last9 = rdata;
      q9.push_back(e);
    end
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < p; k++) begin
        v = (b == glitch && k == p / 2) ? ~fr[b] : fr[b];
        if (sel == 8) rx8 = v; else rx9 = v;
        tick(1);
      end
    end
  endtask

  initial begin
    rx8 = 1'b1; en_par8 = 1'b0; par_type8 = 1'b0; stop2_8 = 1'b0; pre8 = 6'd8;
    rx9 = 1'b1; en_par9 = 1'b0; par_type9 = 1'b0; stop2_9 = 1'b1; pre9 = 6'd16;
    rst_n = 1'b0;
    tick(3);
    check("rst_data8", data8, 64'h0);
    check("rst_flags8", {v8, p8, s8}, 64'h0);
    check("rst_state8", 64'(dut8.state_q === ST_IDLE), 64'd1);
    check("rst_sync8", dut8.rx_s_q, 64'd1);
    check("rst_data9", data9, 64'h0);
    check("rst_flags9", {v9, p9, s9}, 64'h0);
    rst_n = 1'b1;
    idle(8, 4);

    send(8, 9'h0A5, 8, 0, PAR_EVEN, 0, 0, 1, 1, -1);
    idle(8, 8);
    send(8, 9'h03C, 8, 1, PAR_EVEN, 1, 0, 1, 1, -1);
    idle(8, 8);
    send(8, 9'h03C, 8, 1, PAR_ODD, 0, 0, 1, 1, -1);
    idle(8, 8);
    send(8, 9'h000, 8, 0, PAR_EVEN, 0, 0, 0, 1, -1);
    idle(8, 16);
    send(8, 9'h05A, 8, 0, PAR_EVEN, 0, 0, 1, 1, -1);
    idle(8, 8);

    rx8 = 1'b0;
    tick(2);
    rx8 = 1'b1;
    tick(10);
    check("false_start_idle8", 64'(dut8.state_q === ST_IDLE), 64'd1);
    idle(8, 8);

    send(8, 9'h0FF, 8, 0, PAR_EVEN, 0, 0, 1, 1, 4);
    idle(8, 8);

    rx8 = 1'b0;
    tick(30);
    rst_n = 1'b0;
    #1;
    check("abort_data8", data8, 64'h0);
    check("abort_flags8", {v8, p8, s8}, 64'h0);
    check("abort_state8", 64'(dut8.state_q === ST_IDLE), 64'd1);
    rx8 = 1'b1;
    last8 = '0;
    tick(1);
    rst_n = 1'b1;
    idle(8, 16);
    send(8, 9'h081, 8, 1, PAR_ODD, 0, 0, 1, 1, -1);
    idle(8, 8);

    for (int i = 0; i < 100; i++) begin
      send(9, 9'($urandom_range(0, 511)), 16, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 0, 1, 1, 1, -1);
    end
    send(9, 9'h1A5, 16, 1, PAR_ODD, 0, 1, 1, 0, -1);
    idle(9, 32);
    send(9, 9'h0C3, 16, 0, PAR_EVEN, 0, 1, 1, 1, -1);
    idle(9, 16);

    for (int i = 0; i < 400 && (q8.size() != 0 || q9.size() != 0); i++) tick(1);
    check("drain8", q8.size(), 64'd0);
    check("drain9", q9.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised, next-generation UART receiver for the processing unit's serial front end. Recovers DATA_W-bit words from an oversampled asynchronous line. Supports runtime parity enable/type, selectable one or two stop bits and runtime prescale. Reports parity and framing errors instead of silently dropping bad frames, and feeds the command/data path exactly where the current receiver sits.

## Interface
- DATA_W, 8, data bits per frame (5..9)
- PRESCALE_W, 6, width of the prescale input; prescale range 4..2^PRESCALE_W-1
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_rx  in  1  serial line, idle high, asynchronous to i_clk
- i_en_par  in  1  1 = parity bit present after data
- i_par_type  in  1  0 = even, 1 = odd
- i_stop2  in  1  1 = two stop bits, 0 = one
- i_prescale  in  PRESCALE_W  i_clk cycles per bit; legal values ≥4
- o_data  out  DATA_W  last good word, LSB received first
- o_data_valid  out  1  one-cycle pulse: o_data holds a new good word
- o_par_err  out  1  one-cycle pulse: parity mismatch
- o_stop_err  out  1  one-cycle pulse: a stop bit sampled low

## Operation
- i_rx passes through a 2-flop synchroniser (reset value 1). All decisions use the synchronised value rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a falling edge of rx_s (previous 1, current 0).
  - START -> DATA if the start sample is 0; otherwise false start -> IDLE.
  - DATA -> PARITY after DATA_W samples if the parity config is set, else -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE after 1 or 2 stop samples.
- Config is latched on the start-edge cycle: i_en_par, i_par_type, i_stop2, i_prescale. Changes mid-frame have no effect.
- Bit timing:
  - edge_cnt counts 0..prescale-1 within each bit and wraps to 0 at the bit boundary.
  - bit_cnt counts data bits.
  - mid = prescale>>1.
  - Bit value is decided at edge_cnt == mid (see Configuration).
- Data shifts in LSB first into a shift register.
- Parity checking:
  - Even: data XOR parity bit must be 0.
  - Odd: data XOR parity bit must be 1.
  - A mismatch sets a sticky par flag for the frame.
- A stop sample of 0 sets a sticky stop flag. With i_stop2, both stop bits are checked.
- Frame end, in the cycle after the last stop-bit decision:
  - Both flags clear: o_data <= shift register, o_data_valid = 1.
  - Otherwise: o_par_err/o_stop_err pulse per flag; o_data is unchanged; no valid.
- The FSM returns to IDLE at the last stop-bit decision, mid stop bit. This lets back-to-back frames be received with no gap.
- Break (line held low): gives a stop error. No new frame starts until rx_s returns high and falls again.

## Timing
- Reset values: o_data = 0, o_data_valid = 0, o_par_err = 0, o_stop_err = 0, FSM = IDLE, all counters 0, sync flops = 1.
- Reset mid-frame aborts immediately (asynchronous). No pulse is produced for the aborted frame.
- Start edge on rx_s appears 2 cycles after the i_rx transition.
- Output pulse is exactly 1 cycle wide. It occurs at (1 + DATA_W + en_par) × prescale + mid + 1 (+ prescale with i_stop2) cycles after the start edge is detected on rx_s.
- o_data_valid, o_par_err and o_stop_err are registered outputs. o_par_err and o_stop_err may both assert in the same cycle; o_data_valid never asserts together with either error.
- Odd prescale: mid rounds down. Tolerance is ±(mid-1)/prescale of bit time over the frame.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Samples rx_s at edge_cnt = mid-1, mid and mid+1; the bit value is the 2-of-3 majority.
  - The decision is taken at mid+1, so every frame-end pulse moves 1 cycle later.
- Undefined: the bit value is the single sample at edge_cnt = mid.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum;
  - PAR_EVEN = 0, PAR_ODD = 1;
  - the minimum-prescale constant (4).
- Sub-module uart_rx_sampler holds edge_cnt, the sample point(s), majority logic and the bit-done strobe. The top level holds the FSM, shifter, parity/stop checks and outputs.

## Test plan
- DATA_W = 8, prescale 8, no parity, 1 stop, byte 0xA5 -> single o_data_valid, o_data = 0xA5, no errors. Repeat with odd parity and byte 0x3C (parity bit 1) -> valid, 0x3C.
- Even parity, byte 0x3C sent with parity bit 1 -> o_par_err pulse only, no valid, o_data keeps its previous value 0xA5.
- Byte 0x00 with stop bit driven 0, then line high -> o_stop_err pulse only. The next clean frame 0x5A is received correctly.
- i_rx low for 2 cycles at prescale 8 -> false start, no outputs. FSM back in IDLE within 1 bit time.
- DATA_W = 9, prescale 16, two stop bits, 100 back-to-back random words with random parity config -> all received, zero errors. Second stop bit forced low -> o_stop_err.
- Mid-frame i_rst low for 1 cycle -> all outputs 0, FSM in IDLE, no pulse for the aborted frame, next frame OK.
- Majority: 1-cycle glitch at edge_cnt = mid in data bit 3 of 0xFF. With UART_RX_MAJORITY_EN -> 0xFF. Without -> 0xF7.
